// File: rtl/option_encoder.sv
// Option encoder: packs a valid/data pair into a tagged value (tag 0 = Some, 1 = None)
// with a registered side-channel giving a delayed copy, the last Some payload and a Some count.
module option_encoder #(
  parameter int unsigned W  = 16,
  parameter int unsigned CW = 16
) (
  input  logic          _i_clk,
  input  logic          _i_rst,
  input  logic [W-1:0]  _i_x,
  input  logic          _i_valid,
  output logic [W:0]    __output,
  output logic [W:0]    _o_reg,
  output logic [W-1:0]  _o_last_some,
  output logic          _o_has_last,
  output logic [CW-1:0] _o_some_count
);

  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [W:0]    NONE    = {1'b1, {W{1'b0}}};

  // Zero-latency encode; None carries an all-zero payload so it is never X.
  always_comb begin
    __output = NONE;
    if (_i_valid) begin
      __output = {1'b0, _i_x};
    end
  end

  // Registered views of the stream; reset takes priority over a valid sample.
  always_ff @(posedge _i_clk) begin
    if (_i_rst) begin
      _o_reg        <= NONE;
      _o_last_some  <= '0;
      _o_has_last   <= 1'b0;
      _o_some_count <= '0;
    end else begin
      _o_reg <= __output;
      if (_i_valid) begin
        _o_last_some <= _i_x;
        _o_has_last  <= 1'b1;
        if (_o_some_count != CNT_MAX) begin
          _o_some_count <= _o_some_count + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_option_encoder.sv
// Self-checking bench for option_encoder: vector table with a scoreboard queue for the
// registered outputs, plus hand-written combinational and saturation sequences.
module tb_option_encoder;

  logic        clk = 1'b0;
  logic        rst, valid;
  logic [15:0] x;
  logic [16:0] out_c, out_reg;
  logic [15:0] last_some, some_count;
  logic        has_last;

  logic        s_rst, s_valid;
  logic [15:0] s_x;
  logic [16:0] s_out, s_reg;
  logic [15:0] s_last;
  logic        s_has;
  logic [1:0]  s_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  option_encoder #(.W(16), .CW(16)) dut (
    ._i_clk(clk), ._i_rst(rst), ._i_x(x), ._i_valid(valid),
    .__output(out_c), ._o_reg(out_reg), ._o_last_some(last_some),
    ._o_has_last(has_last), ._o_some_count(some_count)
  );

  option_encoder #(.W(16), .CW(2)) dut_sat (
    ._i_clk(clk), ._i_rst(s_rst), ._i_x(s_x), ._i_valid(s_valid),
    .__output(s_out), ._o_reg(s_reg), ._o_last_some(s_last),
    ._o_has_last(s_has), ._o_some_count(s_cnt)
  );

  typedef struct {
    logic        rst;
    logic        valid;
    logic [15:0] x;
    logic [16:0] comb;
    logic [16:0] oreg;
    logic [15:0] last;
    logic        has;
    logic [15:0] cnt;
  } vec_t;

  typedef struct {
    logic [16:0] oreg;
    logic [15:0] last;
    logic        has;
    logic [15:0] cnt;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[14];

  function automatic vec_t mk(logic r, logic v, logic [15:0] xx, logic [16:0] c,
                              logic [16:0] o, logic [15:0] l, logic h, logic [15:0] n);
    vec_t t;
    t.rst = r; t.valid = v; t.x = xx; t.comb = c;
    t.oreg = o; t.last = l; t.has = h; t.cnt = n;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one vector, check the combinational output, queue the registered expectation.
  task automatic apply(input vec_t v, input int idx);
    exp_t e, g;
    rst = v.rst; valid = v.valid; x = v.x;
    #1;
    chk($sformatf("comb[%0d]", idx), 32'(out_c), 32'(v.comb));
    e.oreg = v.oreg; e.last = v.last; e.has = v.has; e.cnt = v.cnt;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_cmp++; n_err++;
      $display("FAIL scoreboard[%0d]: got empty queue expected entry", idx);
    end else begin
      g = sb.pop_front();
      chk($sformatf("reg[%0d]", idx),   32'(out_reg),    32'(g.oreg));
      chk($sformatf("last[%0d]", idx),  32'(last_some),  32'(g.last));
      chk($sformatf("has[%0d]", idx),   32'(has_last),   32'(g.has));
      chk($sformatf("count[%0d]", idx), 32'(some_count), 32'(g.cnt));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; valid = 1'b0; x = 16'd0;
    s_rst = 1'b1; s_valid = 1'b0; s_x = 16'd0;

    // Combinational encode before any clock edge.
    x = 16'd123; valid = 1'b1;
    #1 chk("comb_some_pre_clk", 32'(out_c), 32'h0000_007B);
    valid = 1'b0;
    #1 chk("comb_none_tag", 32'(out_c[16]), 32'd1);
    chk("comb_none_payload", 32'(out_c[15:0]), 32'd0);
    @(posedge clk); #1;

    //            rst   valid  x         comb       reg        last      has   cnt
    vecs[0]  = mk(1'b1, 1'b0, 16'h0000, 17'h10000, 17'h10000, 16'h0000, 1'b0, 16'd0);
    vecs[1]  = mk(1'b0, 1'b1, 16'd123,  17'h0007B, 17'h0007B, 16'd123,  1'b1, 16'd1);
    vecs[2]  = mk(1'b0, 1'b0, 16'd123,  17'h10000, 17'h10000, 16'd123,  1'b1, 16'd1);
    vecs[3]  = mk(1'b1, 1'b0, 16'h0000, 17'h10000, 17'h10000, 16'h0000, 1'b0, 16'd0);
    vecs[4]  = mk(1'b0, 1'b1, 16'd5,    17'h00005, 17'h00005, 16'd5,    1'b1, 16'd1);
    vecs[5]  = mk(1'b0, 1'b1, 16'd6,    17'h00006, 17'h00006, 16'd6,    1'b1, 16'd2);
    vecs[6]  = mk(1'b0, 1'b1, 16'd7,    17'h00007, 17'h00007, 16'd7,    1'b1, 16'd3);
    vecs[7]  = mk(1'b0, 1'b1, 16'd9,    17'h00009, 17'h00009, 16'd9,    1'b1, 16'd4);
    vecs[8]  = mk(1'b0, 1'b0, 16'hBEEF, 17'h10000, 17'h10000, 16'd9,    1'b1, 16'd4);
    vecs[9]  = mk(1'b0, 1'b0, 16'h1234, 17'h10000, 17'h10000, 16'd9,    1'b1, 16'd4);
    vecs[10] = mk(1'b1, 1'b1, 16'd42,   17'h0002A, 17'h10000, 16'h0000, 1'b0, 16'd0);
    vecs[11] = mk(1'b0, 1'b1, 16'hFFFF, 17'h0FFFF, 17'h0FFFF, 16'hFFFF, 1'b1, 16'd1);
    vecs[12] = mk(1'b0, 1'b0, 16'hFFFF, 17'h10000, 17'h10000, 16'hFFFF, 1'b1, 16'd1);
    vecs[13] = mk(1'b0, 1'b1, 16'h0000, 17'h00000, 17'h00000, 16'h0000, 1'b1, 16'd2);

    for (int i = 0; i < 14; i++) begin
      apply(vecs[i], i);
    end

    // Saturation with a 2-bit counter: 1,2,3,3,3.
    s_rst = 1'b1;
    @(posedge clk); #1;
    chk("sat_reset", 32'(s_cnt), 32'd0);
    s_rst = 1'b0; s_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      s_x = 16'(k + 100);
      @(posedge clk); #1;
      chk($sformatf("sat_count[%0d]", k), 32'(s_cnt), (k < 3) ? 32'(k + 1) : 32'd3);
    end
    chk("sat_last", 32'(s_last), 32'd104);
    chk("sat_has", 32'(s_has), 32'd1);

    if (sb.size() != 0) begin
      n_cmp++; n_err++;
      $display("FAIL scoreboard_drain: got %0d left expected 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/option_encoder.md
Name: option_encoder

Overview:
- Packs a data word and a valid flag into an Option-style tagged value. Variant order is `Some(T)` then `None`, so tag 0 = Some and tag 1 = None.
- The primary output is combinational and is the block's core function.
- A small registered side-channel gives pipelined and statistics views of the same stream.
- Sits at the boundary where raw valid/data pairs enter enum-typed logic.

Parameters:
- W, 16, payload width of x. The primary output is W+1 bits.
- CW, 16, width of the Some-counter.

Ports:
- _i_clk  input  1  clock; all registers update on the rising edge.
- _i_rst  input  1  synchronous, active-high reset.
- _i_x  input  W  payload carried in the Some variant.
- _i_valid  input  1  1 = build Some(_i_x); 0 = build None.
- __output  output  W+1  combinational tagged option. Bit W is the tag; bits W-1:0 are the payload.
- _o_reg  output  W+1  __output registered once (1-cycle latency).
- _o_last_some  output  W  payload of the most recent Some accepted by a clock edge.
- _o_has_last  output  1  1 once any Some has been registered since reset.
- _o_some_count  output  CW  saturating count of clock edges with _i_valid=1.

Behaviour:
- Encoding, purely combinational, zero latency, independent of clock and reset:
  - _i_valid=1: __output = {1'b0, _i_x}.
  - _i_valid=0: __output = {1'b1, W'b0}. The payload is driven as 0 for None; it is never X.
  - __output must settle within the same delta/timestep as any input change. No register sits in this path.
- Tag decoding rule for consumers: only bit W is meaningful for None. The payload is valid only when the tag is 0.
- Reset (synchronous, when _i_rst=1 at a rising edge) sets:
  - _o_reg = {1'b1, 0} (None).
  - _o_last_some = 0.
  - _o_has_last = 0.
  - _o_some_count = 0.
- __output is unaffected by reset.
- Registered path, on a rising edge with _i_rst=0:
  - _o_reg <= __output.
  - If _i_valid=1: _o_last_some <= _i_x, _o_has_last <= 1, and _o_some_count <= _o_some_count+1, saturating at 2^CW-1 (no wrap).
  - If _i_valid=0: _o_last_some, _o_has_last and _o_some_count hold their values.
- Reset and valid in the same cycle: reset wins. Nothing is captured and the count stays 0.
- Reset mid-stream: the registered outputs return to their reset values on that edge. Operation resumes on the next non-reset edge.
- No handshake and no backpressure. Every edge samples the inputs.

Test Plan:
- _i_x=123, _i_valid=1 -> __output = 17'h0007B (tag 0, payload 123) in the same timestep, before any clock edge.
- Then _i_valid=0 -> __output[16]=1 and __output[15:0]=0 immediately.
- _i_rst=1 for one edge, then 3 edges with valid=1 carrying x=5,6,7 -> _o_some_count=3, _o_last_some=7, _o_has_last=1, _o_reg={0,7}.
- valid=1 x=9 on one edge, then valid=0 for 2 edges -> _o_reg=None, _o_last_some stays 9, _o_some_count unchanged.
- Reset asserted on the same edge as valid=1 x=42 -> all registered outputs at reset values; __output={0,42} regardless of reset.
- CW=2, valid=1 for 5 edges -> _o_some_count saturates at 3.
